// File: rtl/rng_cfg_arb.sv
// Round-robin arbiter that forwards one channel's rng cfg word at a time and
// locks onto a channel until the rng accepts it (ready arrives at end of range).
module rng_cfg_arb #(
  parameter int NUM   = 2,
  parameter int W_CFG = 48,
  parameter int W_SEL = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM*W_CFG-1:0] din_data,
  input  logic [NUM-1:0]       din_valid,
  output logic [NUM-1:0]       din_ready,
  output logic [W_CFG-1:0]     dout_data,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [W_SEL-1:0]     dout_sel
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state, state_nxt;
  logic [W_SEL-1:0] ptr, ptr_nxt;
  logic [W_SEL-1:0] gnt_q, gnt_nxt;
  logic [W_SEL-1:0] g, rr_g, cand;
  logic             found, vld, hs;

  // Rotating priority search starting at ptr; only indices < NUM are visited.
  always_comb begin
    rr_g  = ptr;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM; k++) begin
      cand = W_SEL'((32'(ptr) + k) % NUM);
      if (!found && din_valid[cand]) begin
        found = 1'b1;
        rr_g  = cand;
      end
    end
  end

  always_comb begin
    if (state == LOCK) begin
      g   = gnt_q;
      vld = din_valid[gnt_q];
    end else begin
      g   = rr_g;
      vld = |din_valid;
    end
    vld = vld & ~rst;
    hs  = vld & dout_ready;
  end

  assign dout_valid = vld;
  assign dout_sel   = g;
  assign dout_data  = din_data[32'(g) * W_CFG +: W_CFG];

  always_comb begin
    din_ready = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      din_ready[i] = hs & (g == W_SEL'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_q;
    if (hs) begin
      state_nxt = IDLE;
      ptr_nxt   = (g == W_SEL'(NUM - 1)) ? '0 : g + 1'b1;
    end else if (state == IDLE && vld) begin
      state_nxt = LOCK;
      gnt_nxt   = g;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt_q <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt_q <= gnt_nxt;
    end
  end

endmodule
